// File: rtl/instr_issue_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : instr_issue_unit                                             |
// | Description : Fetch/issue front end. Reads instruction words from a        |
// |               synchronous memory, buffers them in a 2-entry FIFO and       |
// |               presents decoded fields over a valid/ready handshake.        |
// |               Handles start, redirect flush, halt sentinel and stalls.     |
// | Options     : ISSUE_CNT_EN - adds a 16-bit completed-transfer counter.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module instr_issue_unit #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [5:0]        opcode,
    output logic [5:0]        funct,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [15:0]       imm,
    output logic [ADDR_W-1:0] out_pc,
`ifdef ISSUE_CNT_EN
    output logic [15:0]       issue_count,
`endif
    output logic              halted
);

    localparam logic [ADDR_W-1:0] c_reset_pc = ADDR_W'(RESET_PC);
    localparam logic [5:0]        c_halt_op  = 6'h3F;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [ADDR_W-1:0] r_pc;
    logic              r_inflight;
    logic [ADDR_W-1:0] r_inflight_pc;

    // Two-entry buffer kept as head/tail registers; empty entries hold zeros
    // so the head can drive the field outputs directly.
    logic              r_head_vld;
    logic [31:0]       r_head_instr;
    logic [ADDR_W-1:0] r_head_pc;
    logic              r_tail_vld;
    logic [31:0]       r_tail_instr;
    logic [ADDR_W-1:0] r_tail_pc;

    logic       w_flush;
    logic       w_pop;
    logic       w_push;
    logic       w_push_halt;
    logic       w_issue;
    logic [1:0] w_slots;

    assign w_flush     = start | redirect_valid;
    assign w_pop       = r_head_vld & out_ready;
    assign w_push      = r_inflight & ~w_flush;
    assign w_push_halt = w_push & (imem_rdata[31:26] == c_halt_op);

    // Slots committed after this edge: entry leaving on a pop is already free,
    // which lets the pipeline sustain one instruction per cycle.
    assign w_slots = 2'(r_head_vld) + 2'(r_tail_vld) + 2'(r_inflight) - 2'(w_pop);
    assign w_issue = (r_state == ST_RUN) & ~w_flush & (w_slots < 2'd2);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and memory-port outputs
    always_comb begin
        w_state_nxt = r_state;
        imem_en     = 1'b0;
        imem_addr   = '0;
        halted      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_flush) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_flush) begin
                    w_state_nxt = ST_RUN;
                end else if (w_push_halt) begin
                    w_state_nxt = ST_HALT;
                end
            end
            ST_HALT: begin
                if (w_flush) begin
                    w_state_nxt = ST_RUN;
                end
                halted = ~r_head_vld;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (w_issue) begin
            imem_en   = 1'b1;
            imem_addr = r_pc;
        end
    end

    // PC sequencing: redirect beats start, otherwise advance on each read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= c_reset_pc;
        end else if (redirect_valid) begin
            r_pc <= redirect_pc;
        end else if (start) begin
            r_pc <= c_reset_pc;
        end else if (w_issue) begin
            r_pc <= r_pc + ADDR_W'(1);
        end
    end

    // In-flight tag; a read issued alongside a halt capture is dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else begin
            r_inflight <= w_issue & ~w_push_halt;
            if (w_issue) begin
                r_inflight_pc <= r_pc;
            end
        end
    end

    // Output buffer push/pop with flush on start or redirect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head_vld   <= 1'b0;
            r_head_instr <= '0;
            r_head_pc    <= '0;
            r_tail_vld   <= 1'b0;
            r_tail_instr <= '0;
            r_tail_pc    <= '0;
        end else if (w_flush) begin
            r_head_vld   <= 1'b0;
            r_head_instr <= '0;
            r_head_pc    <= '0;
            r_tail_vld   <= 1'b0;
            r_tail_instr <= '0;
            r_tail_pc    <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b11: begin
                    if (r_tail_vld) begin
                        r_head_instr <= r_tail_instr;
                        r_head_pc    <= r_tail_pc;
                        r_tail_instr <= imem_rdata;
                        r_tail_pc    <= r_inflight_pc;
                    end else begin
                        r_head_instr <= imem_rdata;
                        r_head_pc    <= r_inflight_pc;
                    end
                end
                2'b10: begin
                    if (r_head_vld) begin
                        r_tail_vld   <= 1'b1;
                        r_tail_instr <= imem_rdata;
                        r_tail_pc    <= r_inflight_pc;
                    end else begin
                        r_head_vld   <= 1'b1;
                        r_head_instr <= imem_rdata;
                        r_head_pc    <= r_inflight_pc;
                    end
                end
                2'b01: begin
                    r_head_vld   <= r_tail_vld;
                    r_head_instr <= r_tail_instr;
                    r_head_pc    <= r_tail_pc;
                    r_tail_vld   <= 1'b0;
                    r_tail_instr <= '0;
                    r_tail_pc    <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    assign out_valid = r_head_vld;
    assign out_pc    = r_head_pc;
    assign opcode    = r_head_instr[31:26];
    assign rs        = r_head_instr[25:21];
    assign rt        = r_head_instr[20:16];
    assign rd        = r_head_instr[15:11];
    assign imm       = r_head_instr[15:0];
    assign funct     = r_head_instr[5:0];

`ifdef ISSUE_CNT_EN
    logic [15:0] r_issue_count;

    // Completed-transfer counter; start clears it, redirect does not
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_issue_count <= '0;
        end else if (start) begin
            r_issue_count <= '0;
        end else if (w_pop) begin
            r_issue_count <= r_issue_count + 16'd1;
        end
    end

    assign issue_count = r_issue_count;
`else
    // Transfer counter not present in this build.
`endif

endmodule
`default_nettype wire

// File: doc/instr_issue_unit.md
# instr_issue_unit

Front-end fetch/issue block for the single-cycle MIPS-style lab datapath. Fetches 32-bit instruction words from a synchronous instruction memory, splits them into opcode/funct/register/immediate fields, and presents them to the control unit and register file through a valid/ready handshake. It is the producer side of the opcode/funct interface that `control_unit` consumes. It provides PC sequencing, redirect (branch/jump) flush, halt detection, and backpressure buffering.

## Interface
- `ADDR_W`, 8: word-address width of instruction memory.
- `RESET_PC`, 0: word address loaded into the PC on reset and on `start`.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `start` input 1: one-cycle pulse. Loads PC with `RESET_PC`, flushes state and enters RUN.
- `redirect_valid` input 1: one-cycle pulse. Replaces PC and flushes.
- `redirect_pc` input ADDR_W: new word address, valid when `redirect_valid`=1.
- `imem_en` output 1: read enable to instruction memory.
- `imem_addr` output ADDR_W: word address of the read.
- `imem_rdata` input 32: read data, valid exactly one cycle after `imem_en`=1.
- `out_valid` output 1: issued instruction available.
- `out_ready` input 1: downstream accepts. A transfer completes when `out_valid` && `out_ready` at a rising edge.
- `opcode` output 6: instr[31:26].
- `funct` output 6: instr[5:0].
- `rs`, `rt`, `rd` output 5 each: instr[25:21], instr[20:16], instr[15:11].
- `imm` output 16: instr[15:0].
- `out_pc` output ADDR_W: word address of the presented instruction.
- `halted` output 1: HALT state and output buffer empty.

## Operation
- FSM states: IDLE (reset state), RUN, HALT.
  - IDLE→RUN on `start`.
  - RUN→HALT when a word with opcode 6'h3F (halt sentinel) is captured.
  - HALT→RUN on `start` or `redirect_valid`.
  - `redirect_valid` in IDLE loads PC and enters RUN.
- Output buffer: 2-entry FIFO of {instr, pc}. Outputs are driven from the head entry. `out_valid` = buffer non-empty.
- Read issue rule in RUN: `imem_en`=1 iff (occupancy + in-flight reads) < 2, and no redirect or start this cycle. Each issued read:
  - `imem_addr` = PC;
  - PC ← PC+1, modulo 2^ADDR_W (wraps from all-ones to 0);
  - the in-flight tag is set.
- Capture: the cycle after an issued read, `imem_rdata` and its PC are pushed into the buffer at the rising edge.
- Halt word: pushed and presented downstream like any other word. Any read already in flight behind it is discarded. No further reads are issued in HALT.
- Redirect or start (redirect has priority if both are high):
  - at the edge, buffer cleared, in-flight read discarded, PC ← target;
  - a transfer completing on the same edge is still counted as delivered;
  - next cycle `out_valid`=0 and `imem_en`=1 with `imem_addr`=target.
- Simultaneous push and pop when buffer full-minus-one or full: occupancy stays unchanged. The FIFO never overflows because of the issue rule.
- Field outputs: registered copies of the head entry, and 0 when empty.
- Reset values: state=IDLE, PC=`RESET_PC`, buffer empty, no read in flight. All outputs 0, including `imem_en`, `out_valid`, `halted`, all fields and `out_pc`.
- Reset mid-operation: immediate return to reset values. Memory data arriving after reset is ignored.

## Timing
- Start latency, with `start` sampled at edge E0:
  - `imem_en`=1 and `imem_addr`=`RESET_PC` during cycle E0–E1;
  - data captured at E2;
  - `out_valid`=1 from E2.
- Throughput: one instruction per cycle while `out_ready`=1 continuously.
- Redirect latency: first redirected instruction valid 2 edges after the redirect edge.
- When `out_ready` is deasserted, a valid output and its fields hold stable until accepted.
- `halted` rises on the edge at which the halt word is popped.

## Configuration
- `ISSUE_CNT_EN` defined:
  - adds output `issue_count` [15:0], reset 0;
  - increments by 1 on every completed transfer and wraps at 16'hFFFF→0;
  - cleared by `start`, not by redirect.
- `ISSUE_CNT_EN` undefined: port and counter absent. All other behaviour is identical.

## Test plan
- Reset then `start`, memory words 0..3 = 0x012A4020, 0x8D090004, 0xAD090008, 0xFC000000, `out_ready`=1:
  - first `out_valid` 2 edges after start;
  - opcode/funct sequence 00/20, 23/04, 2B/08, 3F/00 on consecutive cycles;
  - then `halted`=1 and `imem_en`=0.
- Backpressure: `out_ready`=0 for 5 cycles mid-stream:
  - `imem_en` drops after 2 reads are outstanding or buffered;
  - fields hold; no instruction is lost or duplicated;
  - `out_pc` sequence stays contiguous.
- `redirect_valid` with `redirect_pc`=0x40 while 2 entries are buffered:
  - next cycle `out_valid`=0 and `imem_addr`=0x40;
  - the next delivered `out_pc`=0x40.
- PC wrap with ADDR_W=8, `RESET_PC`=0xFE: delivered `out_pc` sequence 0xFE, 0xFF, 0x00.
- `rst` asserted asynchronously mid-stream: all outputs 0 immediately; after `start`, fetch restarts at `RESET_PC`.
- With `ISSUE_CNT_EN`: 4 transfers → `issue_count`=4; a further `start` → 0.
